// File: rtl/mod_updown_counter_pkg.sv
// Shared constants for the modulo up/down counter slice: default sizing, the
// BCD digit limit and the MODULO-1 decode value used by the compare network.
package mod_updown_counter_pkg;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_MODULO = 10;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Terminal value of the count range; it is decoded into constant AND/OR gates.
  function automatic int mod_max(input int modulo);
    return modulo - 1;
  endfunction

endpackage

// File: rtl/mod_updown_counter_cnt_bit_slice.sv
// Lab cell library (DFF, MUX21, XOR2, AND2, OR2, INV) and the per-bit counter
// slice built from those cells.
module lab_dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

module lab_mux21 (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module lab_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module lab_and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module lab_or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module lab_inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module cnt_bit_slice #(
  parameter logic MAX_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic load,
  input  logic wrap,
  input  logic d,
  input  logic carry_in,
  input  logic borrow_n_in,
  output logic carry_out,
  output logic borrow_n_out,
  output logic q
);
  logic borrow_in;
  logic toggle;
  logic count_bit;
  logic wrap_bit;
  logic step_bit;
  logic count_d;

  // The borrow chain runs active-low so an OR2 can propagate "all lower bits are zero".
  lab_and2  u_carry    (.a(carry_in),    .b(q),          .y(carry_out));
  lab_or2   u_borrow   (.a(borrow_n_in), .b(q),          .y(borrow_n_out));
  lab_inv   u_borrow_i (.a(borrow_n_in),                 .y(borrow_in));
  lab_mux21 u_dir      (.sel(up),   .a(borrow_in), .b(carry_in),  .y(toggle));
  lab_xor2  u_toggle   (.a(q),           .b(toggle),     .y(count_bit));
  lab_mux21 u_wrap_val (.sel(up),   .a(MAX_BIT),   .b(1'b0),      .y(wrap_bit));
  lab_mux21 u_wrap     (.sel(wrap), .a(count_bit), .b(wrap_bit),  .y(step_bit));
  lab_mux21 u_load     (.sel(load), .a(step_bit),  .b(d),         .y(count_d));
  lab_dff   u_dff      (.clk(clk), .reset(reset), .d(count_d), .q(q));
endmodule

// File: rtl/mod_updown_counter.sv
// Structural modulo-N up/down counter with parallel load; TC anticipates the
// wrap so a cascaded instance steps on the same edge.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int MODULO = DEFAULT_MODULO
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(mod_max(MODULO));

  logic             reset;
  logic             en_n;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   borrow_n;
  logic [WIDTH:0]   ge_chain;
  logic [WIDTH:0]   nz_chain;
  logic             at_zero;
  logic             tc_sel;
  logic             unused_chain_ends;

  lab_inv u_rst_inv (.a(RESET_N), .y(reset));
  lab_inv u_en_inv  (.a(EN),      .y(en_n));

  // EN seeds both ripple chains, so a disabled counter never toggles any bit.
  assign carry[0]    = EN;
  assign borrow_n[0] = en_n;
  assign ge_chain[0] = 1'b1;
  assign nz_chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (MAX_VAL[i]) begin : g_ge_and
      lab_and2 u_ge (.a(Q[i]), .b(ge_chain[i]), .y(ge_chain[i+1]));
    end else begin : g_ge_or
      lab_or2 u_ge (.a(Q[i]), .b(ge_chain[i]), .y(ge_chain[i+1]));
    end

    lab_or2 u_nz (.a(Q[i]), .b(nz_chain[i]), .y(nz_chain[i+1]));

    cnt_bit_slice #(.MAX_BIT(MAX_VAL[i])) u_slice (
      .clk          (CLK),
      .reset        (reset),
      .up           (UP),
      .load         (LOAD),
      .wrap         (TC),
      .d            (D[i]),
      .carry_in     (carry[i]),
      .borrow_n_in  (borrow_n[i]),
      .carry_out    (carry[i+1]),
      .borrow_n_out (borrow_n[i+1]),
      .q            (Q[i])
    );
  end

  lab_inv   u_zero   (.a(nz_chain[WIDTH]), .y(at_zero));
  lab_mux21 u_tc_dir (.sel(UP), .a(at_zero), .b(ge_chain[WIDTH]), .y(tc_sel));
  lab_and2  u_tc_en  (.a(EN), .b(tc_sel), .y(TC));

  lab_or2 u_chain_ends (.a(carry[WIDTH]), .b(borrow_n[WIDTH]), .y(unused_chain_ends));
endmodule
